serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits (legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to add the operands presented this cycle.
REQ-005 The block SHALL have port A, input, WIDTH bits, operand A, unsigned.
REQ-006 The block SHALL have port B, input, WIDTH bits, operand B, unsigned.
REQ-007 The block SHALL have port Ci, input, 1 bit, the carry-in of the addition.
REQ-008 The block SHALL have port busy, output, 1 bit, high while an addition is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a new result on S/Cout.
REQ-010 The block SHALL have port S, output, WIDTH bits, the sum of the last completed addition.
REQ-011 The block SHALL have port Cout, output, 1 bit, the carry-out of the last completed addition.

Function
REQ-012 The FSM SHALL have two states: IDLE (busy=0) and RUN (busy=1).
REQ-013 In IDLE, start=1 at an edge SHALL load A, B into shift registers, load Ci into the carry flip-flop, clear the bit counter, and enter RUN.
REQ-014 In IDLE, start=0 SHALL leave all state unchanged.
REQ-015 In RUN, each edge SHALL add one bit LSB-first using one full-adder cell (operand-A LSB, operand-B LSB, carry flip-flop).
REQ-016 In RUN, each edge SHALL shift the sum bit into the result register from the MSB side, shift the operand registers right by one, and store the carry.
REQ-017 Each RUN edge SHALL increment the counter, which is ceil(log2(WIDTH+1)) bits wide.
REQ-018 The counter SHALL NOT wrap; the RUN edge that processes bit WIDTH-1 SHALL return the FSM to IDLE.
REQ-019 That final RUN edge SHALL update S to the full sum and Cout to the final carry, and set done=1.
REQ-020 Latency: if start is sampled at edge 0, bits SHALL be processed at edges 1..WIDTH, with done=1 only during the cycle after edge WIDTH.
REQ-021 done SHALL be high for exactly one cycle per accepted start.
REQ-022 S and Cout SHALL hold their value until the next completion or reset; they SHALL NOT change during RUN.
REQ-023 start SHALL be ignored while busy=1; A, B and Ci changes during RUN SHALL NOT affect the result.
REQ-024 start=1 in the cycle where done=1 SHALL be accepted, giving back-to-back operation with one addition every WIDTH+1 cycles.
REQ-025 The result SHALL equal (A + B + Ci) mod 2^(WIDTH+1), split as {Cout, S}.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE and set busy=0, done=0, S=0, Cout=0, counter=0, carry=0, and operand registers=0.
REQ-027 rst SHALL take priority over start and over RUN progress; an addition interrupted by reset SHALL produce no done pulse.
REQ-028 The first edge after rst deasserts SHALL behave as IDLE and accept start.

Structure
REQ-029 The state encoding (IDLE, RUN) and the default WIDTH constant SHALL live in a shared package, serial_adder_pkg.
REQ-030 The per-bit addition SHALL be one instance of the existing 1-bit full-adder cell sum1bcc (ports Ci, A, B, S, Cout), with no other arithmetic.
REQ-031 All registers SHALL be in a single clocked process; next-state and output logic SHALL be synchronous, with no latches.

Verification
REQ-032 With WIDTH=4, A=0101, B=0011, Ci=0, start pulsed at edge 0, the bench SHALL see busy=1 over edges 1..4, done=1 after edge 4, S=1000, Cout=0.
REQ-033 With A=1111, B=0001, Ci=0, the bench SHALL see S=0000, Cout=1; with A=1111, B=1111, Ci=1, it SHALL see S=1111, Cout=1.
REQ-034 A start with A=0001 applied mid-RUN, with A changed during RUN, SHALL be ignored, and the bench SHALL see only the original result and a single done.
REQ-035 rst asserted at edge 2 of RUN SHALL give busy=0, S=0, Cout=0 and no done; a new start afterwards SHALL give a correct result.
REQ-036 Back-to-back starts (start held high) SHALL produce done every 5 cycles with correct results.
REQ-037 An exhaustive run of all 512 {A, B, Ci} combinations SHALL match a reference sum exactly.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default operand width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sum1bcc.sv
// One-bit full-adder cell: the only arithmetic element of the serial adder.
module sum1bcc (
  input  logic Ci,
  input  logic A,
  input  logic B,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Ci;
  assign Cout = (A & B) | (A & Ci) | (B & Ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one full-adder cell processes the operands LSB-first,
// one bit per clock, and publishes {Cout, S} with a one-cycle done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [WIDTH-1:0] s_reg;
  logic             cout_reg;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] res_next;

  sum1bcc u_fa (
    .Ci   (carry_reg),
    .A    (a_reg[0]),
    .B    (b_reg[0]),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // Sum bits enter from the MSB side so the first (LSB) bit ends up at bit 0.
  assign res_next = {fa_s, res_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      s_reg     <= '0;
      cout_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Ci;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= fa_cout;
          res_reg   <= res_next;
          cnt_reg   <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_BIT) begin
            s_reg     <= res_next;
            cout_reg  <= fa_cout;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign S    = s_reg;
  assign Cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=4.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       Ci;
  logic       busy;
  logic       done;
  logic [3:0] S;
  logic       Cout;

  int checks = 0;
  int errors = 0;
  logic [3:0] last_s;
  logic       last_c;

  serial_adder #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Ci    (Ci),
    .busy  (busy),
    .done  (done),
    .S     (S),
    .Cout  (Cout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one start and follows the addition to its done cycle; operands are
  // scrambled right after acceptance to show they are no longer sampled.
  task automatic run_add(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         input logic [3:0] es, input logic ec, input string tag, input bit detail);
    start = 1'b1; A = a; B = b; Ci = ci;
    step();
    start = 1'b0; A = ~a; B = ~b; Ci = ~ci;
    for (int k = 0; k < 4; k++) begin
      if (detail) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_nodone"}, 32'(done), 32'd0);
        check({tag, "_shold"}, 32'({Cout, S}), 32'({last_c, last_s}));
      end
      step();
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_sum"}, 32'({Cout, S}), 32'({ec, es}));
    last_s = es;
    last_c = ec;
    $display("add %s A=%b B=%b Ci=%b -> Cout=%b S=%b", tag, a, b, ci, Cout, S);
    if (detail) begin
      step();
      check({tag, "_donefall"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; A = 4'h0; B = 4'h0; Ci = 1'b0;
    last_s = 4'h0; last_c = 1'b0;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'({Cout, S}), 32'd0);
    rst = 1'b0;

    // 0101 + 0011 + 0 = 1000, carry 0
    run_add(4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, "basic", 1'b1);
    // 1111 + 0001 + 0 = 1_0000
    run_add(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, "wrap", 1'b1);
    // 1111 + 1111 + 1 = 1_1111
    run_add(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, "max", 1'b1);

    // Start attempts during RUN must be ignored.
    start = 1'b1; A = 4'b0101; B = 4'b0011; Ci = 1'b0;
    step();
    A = 4'b0001; B = 4'b0000;
    step();
    A = 4'b1010;
    step();
    step();
    check("midrun_busy", 32'(busy), 32'd1);
    start = 1'b0;
    step();
    check("midrun_done", 32'(done), 32'd1);
    check("midrun_sum", 32'({Cout, S}), 32'b0_1000);
    $display("add midrun A=0101 B=0011 Ci=0 -> Cout=%b S=%b", Cout, S);
    last_s = 4'b1000; last_c = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      check("midrun_single", 32'(done), 32'd0);
    end

    // Reset at edge 2 of a run aborts it without a done pulse.
    run_add(4'b1001, 4'b1000, 1'b1, 4'b0010, 1'b1, "prerst", 1'b0);
    start = 1'b1; A = 4'b0111; B = 4'b0110; Ci = 1'b0;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'({Cout, S}), 32'd0);
    last_s = 4'h0; last_c = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("abort_nodone", 32'(done), 32'd0);
      step();
    end
    $display("reset abort: busy=%b Cout=%b S=%b", busy, Cout, S);
    run_add(4'b0111, 4'b0110, 1'b0, 4'b1101, 1'b0, "postrst", 1'b1);

    // Back-to-back: start held high, one result every 5 cycles.
    start = 1'b1; A = 4'b0011; B = 4'b0100; Ci = 1'b1;
    step();
    A = 4'b1100; B = 4'b0101; Ci = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("b2b1_nodone", 32'(done), 32'd0);
      step();
    end
    check("b2b1_done", 32'(done), 32'd1);
    check("b2b1_sum", 32'({Cout, S}), 32'b0_1000);
    $display("add b2b1 A=0011 B=0100 Ci=1 -> Cout=%b S=%b", Cout, S);
    step();
    A = 4'b1000; B = 4'b1000; Ci = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("b2b2_nodone", 32'(done), 32'd0);
      step();
    end
    check("b2b2_done", 32'(done), 32'd1);
    check("b2b2_sum", 32'({Cout, S}), 32'b1_0001);
    $display("add b2b2 A=1100 B=0101 Ci=0 -> Cout=%b S=%b", Cout, S);
    step();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("b2b3_nodone", 32'(done), 32'd0);
      step();
    end
    check("b2b3_done", 32'(done), 32'd1);
    check("b2b3_sum", 32'({Cout, S}), 32'b1_0001);
    $display("add b2b3 A=1000 B=1000 Ci=1 -> Cout=%b S=%b", Cout, S);
    step();
    last_s = 4'b0001; last_c = 1'b1;

    // Exhaustive sweep against the arithmetic reference.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] ea;
      logic [3:0] eb;
      logic       ec;
      logic [4:0] ref_sum;
      ea = 4'(i >> 5);
      eb = 4'(i >> 1);
      ec = i[0];
      ref_sum = 5'(ea) + 5'(eb) + 5'(ec);
      run_add(ea, eb, ec, ref_sum[3:0], ref_sum[4], "sweep", 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
